viterbi_link_ctrl: RTL

Frame sequencer for the convolutional-encode / channel / Viterbi-decode link. It pulls payload bits from a source over a valid/ready handshake and drives the link's encoder input and enable. After each frame it appends zero tail bits to terminate the trellis, then waits out the link's fixed decode latency. Decoded output is qualified with a valid strobe aligned to payload bits only, and the block counts delivered words and optionally schedules channel error injection.

---
 rtl/viterbi_link_ctrl.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/viterbi_link_ctrl.sv
// viterbi_link_ctrl
// Frame sequencer for a convolutional-encode / channel / Viterbi-decode link.
// It pulls payload bits from a valid/ready source and drives the encoder input
// and its enable. After the payload it appends TAIL_LEN zero bits to
// terminate the trellis, then waits out the fixed decode latency. A tag
// pipeline of depth DEC_LAT marks which decoded bits are payload bits.
//
// Optional feature: define VTR_ERR_INJ_EN to schedule channel error injection
// on every ERR_PERIOD-th payload bit (err_inj_o is tied low otherwise).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start_i             begin a frame (sampled only while idle)
//   src_valid_i/_data_i source payload bit and its qualifier
//   src_ready_o         a bit is accepted this cycle when src_valid_i is high
//   encoder_o           bit to link encoder, qualified by enable_encoder_o
//   decoder_i           decoded bit returning from the link
//   dec_data_o          registered decoded bit, qualified by dec_valid_o
//   err_inj_o           error-injection request, aligned with encoder_o
//   word_ct_o           payload bits delivered this frame (saturating)
//   busy_o              sequencer not idle
//   frame_done_o        one-cycle end-of-frame pulse
module viterbi_link_ctrl #(
    parameter int FRAME_LEN  = 256,
    parameter int TAIL_LEN   = 2,
    parameter int DEC_LAT    = 64,
    parameter int ERR_PERIOD = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        src_valid_i,
    input  logic        src_data_i,
    output logic        src_ready_o,
    output logic        encoder_o,
    output logic        enable_encoder_o,
    input  logic        decoder_i,
    output logic        dec_data_o,
    output logic        dec_valid_o,
    output logic        err_inj_o,
    output logic [15:0] word_ct_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam int PCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int TCW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
    localparam int DCW = $clog2(DEC_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAYLOAD = 3'd1,
        S_TAIL    = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [PCW-1:0]     pay_cnt_q, pay_cnt_d;
    logic [TCW-1:0]     tail_cnt_q, tail_cnt_d;
    logic [DCW-1:0]     drain_cnt_q, drain_cnt_d;
    logic               start_s, xfer_s;
    logic               encoder_q, encoder_d;
    logic               enable_q, enable_d;
    logic               tag_q, tag_d;
    logic [DEC_LAT-1:0] tag_pipe_q, tag_pipe_d;
    logic [DEC_LAT:0]   tag_pipe_ext_s;
    logic               dec_valid_q, dec_valid_d;
    logic               dec_data_q;
    logic [15:0]        word_ct_q, word_ct_d;
    logic               frame_done_q, frame_done_d;

    assign start_s     = (state_q == S_IDLE) & start_i;
    // Ready is a pure decode of the state so it drops the cycle after the last transfer.
    assign src_ready_o = (state_q == S_PAYLOAD);
    assign xfer_s      = src_ready_o & src_valid_i;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pay_cnt_q   <= {PCW{1'b0}};
            tail_cnt_q  <= {TCW{1'b0}};
            drain_cnt_q <= {DCW{1'b0}};
        end else begin
            state_q     <= state_d;
            pay_cnt_q   <= pay_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state and phase counters.
    always_comb begin
        state_d     = state_q;
        pay_cnt_d   = pay_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_PAYLOAD;
                    pay_cnt_d = {PCW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (xfer_s) begin
                    if (pay_cnt_q == PCW'(FRAME_LEN - 1)) begin
                        state_d    = S_TAIL;
                        tail_cnt_d = {TCW{1'b0}};
                    end else begin
                        pay_cnt_d = pay_cnt_q + PCW'(1);
                    end
                end else begin
                    state_d = S_PAYLOAD;
                end
            end
            S_TAIL: begin
                if (tail_cnt_q == TCW'(TAIL_LEN - 1)) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = {DCW{1'b0}};
                end else begin
                    tail_cnt_d = tail_cnt_q + TCW'(1);
                end
            end
            S_DRAIN: begin
                // One cycle beyond the decode latency lets the last tag leave the pipeline.
                if (drain_cnt_q == DCW'(DEC_LAT)) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        encoder_d = 1'b0;
        enable_d  = 1'b0;
        tag_d     = 1'b0;
        case (state_q)
            S_PAYLOAD: begin
                if (xfer_s) begin
                    encoder_d = src_data_i;
                    enable_d  = 1'b1;
                    tag_d     = 1'b1;
                end else begin
                    encoder_d = 1'b0;
                    enable_d  = 1'b0;
                    tag_d     = 1'b0;
                end
            end
            S_TAIL: begin
                encoder_d = 1'b0;
                enable_d  = 1'b1;
                tag_d     = 1'b0;
            end
            default: begin
                encoder_d = 1'b0;
                enable_d  = 1'b0;
                tag_d     = 1'b0;
            end
        endcase
        tag_pipe_ext_s = {tag_pipe_q, tag_q};
        tag_pipe_d     = tag_pipe_ext_s[DEC_LAT-1:0];
        dec_valid_d    = tag_pipe_q[DEC_LAT-1];
        frame_done_d   = (state_q == S_DONE);
        if (start_s) begin
            word_ct_d = 16'h0000;
        end else if (dec_valid_d && (word_ct_q != 16'hFFFF)) begin
            word_ct_d = word_ct_q + 16'h0001;
        end else begin
            word_ct_d = word_ct_q;
        end
    end

    // Registered outputs and tag pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            encoder_q    <= 1'b0;
            enable_q     <= 1'b0;
            tag_q        <= 1'b0;
            tag_pipe_q   <= {DEC_LAT{1'b0}};
            dec_valid_q  <= 1'b0;
            dec_data_q   <= 1'b0;
            word_ct_q    <= 16'h0000;
            frame_done_q <= 1'b0;
        end else begin
            encoder_q    <= encoder_d;
            enable_q     <= enable_d;
            tag_q        <= tag_d;
            tag_pipe_q   <= tag_pipe_d;
            dec_valid_q  <= dec_valid_d;
            dec_data_q   <= decoder_i;
            word_ct_q    <= word_ct_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef VTR_ERR_INJ_EN
    localparam int ECW = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;

    logic [ECW-1:0] err_cnt_q, err_cnt_d;
    logic           err_q, err_d;

    // Error-injection spacing counter, restarted with every frame.
    always_comb begin
        err_cnt_d = err_cnt_q;
        err_d     = 1'b0;
        if (start_s) begin
            err_cnt_d = {ECW{1'b0}};
        end else if (xfer_s) begin
            if (err_cnt_q == ECW'(ERR_PERIOD - 1)) begin
                err_d     = 1'b1;
                err_cnt_d = {ECW{1'b0}};
            end else begin
                err_cnt_d = err_cnt_q + ECW'(1);
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error-injection registers, aligned with the encoder output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= {ECW{1'b0}};
            err_q     <= 1'b0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err_inj_o = err_q;
`else
    // The injection period only matters when injection is compiled in.
    localparam int ERR_PERIOD_UNUSED = ERR_PERIOD;
    assign err_inj_o = 1'b0;
`endif

    assign encoder_o        = encoder_q;
    assign enable_encoder_o = enable_q;
    assign dec_valid_o      = dec_valid_q;
    assign dec_data_o       = dec_data_q;
    assign word_ct_o        = word_ct_q;
    assign busy_o           = (state_q != S_IDLE);
    assign frame_done_o     = frame_done_q;

endmodule
